// File: rtl/esc_pkg.sv
// Shared types and defaults for the quad ESC driver: arming state encoding,
// pulse-width type and the default timing constants for a 50 MHz clock.
package esc_pkg;

    // Arming state machine encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ARMED  = 2'd2
    } esc_state_e;

    // Default pulse timing: 1 ms base pulse at 50 MHz, 3 cycles per speed LSB
    localparam int unsigned BASE_PULSE_DEF = 32'd50000;
    localparam int unsigned SPD_MULT_DEF   = 32'd3;

    // Field widths
    localparam int unsigned SPD_W   = 32'd11;
    localparam int unsigned OFF_W   = 32'd10;
    localparam int unsigned WIDTH_W = 32'd17;

    // Pulse width in clock cycles
    typedef logic [WIDTH_W-1:0] width_t;

    // Largest width any channel can request: full-scale speed plus the given trim
    function automatic longint unsigned max_width(input longint unsigned base,
                                                  input longint unsigned mult,
                                                  input longint unsigned off);
        return base + ((64'd1 << SPD_W) - 64'd1) * mult + off;
    endfunction

endpackage

// File: rtl/esc_chan.sv
// One ESC output channel: computes the pulse width for the coming frame,
// holds it in a shadow register that only changes on the frame boundary,
// and drives a registered PWM pin from the shared frame counter.
module esc_chan
    import esc_pkg::*;
#(
    parameter int unsigned      PERIOD_BITS = 32'd20,
    parameter int unsigned      BASE_PULSE  = BASE_PULSE_DEF,
    parameter int unsigned      SPD_MULT    = SPD_MULT_DEF,
    parameter logic [OFF_W-1:0] OFF         = 10'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  esc_state_e             mode,
    input  logic [SPD_W-1:0]       spd,
    input  logic [PERIOD_BITS-1:0] cnt_nxt,
    output logic                   pwm
);

    // Compare width wide enough for both the counter and the pulse width
    localparam int unsigned CMP_W = (PERIOD_BITS > WIDTH_W) ? PERIOD_BITS : WIDTH_W;

    localparam width_t BASE_W = width_t'(BASE_PULSE);
    localparam width_t MULT_W = width_t'(SPD_MULT);
    localparam width_t OFF_X  = width_t'(OFF);

    width_t           width_new_s;
    width_t           shadow_nxt_s;
    width_t           shadow_r;
    logic [CMP_W-1:0] cnt_ext_s;
    logic [CMP_W-1:0] shadow_ext_s;
    logic             pwm_nxt_s;
    logic             pwm_r;

    // Width for the frame about to start, following the rule of the state being entered
    always_comb begin
        width_new_s = 17'd0;
        case (mode)
            IDLE:    width_new_s = 17'd0;
            ARMING:  width_new_s = BASE_W + OFF_X;
            ARMED:   width_new_s = BASE_W + (width_t'(spd) * MULT_W) + OFF_X;
            default: width_new_s = 17'd0;
        endcase
    end

    // Shadow follows the new width only on the boundary; the PWM compare uses the
    // post-boundary value so the first cycle of a frame already sees the new width
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (load) begin
            shadow_nxt_s = width_new_s;
        end else begin
            shadow_nxt_s = shadow_r;
        end
        cnt_ext_s    = CMP_W'(cnt_nxt);
        shadow_ext_s = CMP_W'(shadow_nxt_s);
        pwm_nxt_s    = (cnt_ext_s < shadow_ext_s);
    end

    // Shadow width and PWM pin registers; reset drops the pin immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= 17'd0;
            pwm_r    <= 1'b0;
        end else begin
            shadow_r <= shadow_nxt_s;
            pwm_r    <= pwm_nxt_s;
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/esc_quad.sv
// Four-channel ESC driver. A free-running frame counter defines servo frames;
// speeds and the arm request are sampled only at the frame boundary, where an
// arming state machine advances and all four channel shadow widths reload.
module esc_quad
    import esc_pkg::*;
#(
    parameter int unsigned      PERIOD_BITS = 32'd20,
    parameter int unsigned      BASE_PULSE  = BASE_PULSE_DEF,
    parameter int unsigned      SPD_MULT    = SPD_MULT_DEF,
    parameter logic [OFF_W-1:0] FRNT_OFF    = 10'd0,
    parameter logic [OFF_W-1:0] BCK_OFF     = 10'd0,
    parameter logic [OFF_W-1:0] LFT_OFF     = 10'd0,
    parameter logic [OFF_W-1:0] RGHT_OFF    = 10'd0,
    parameter int unsigned      ARM_FRAMES  = 32'd64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic [SPD_W-1:0] frnt_spd,
    input  logic [SPD_W-1:0] bck_spd,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             frnt,
    output logic             bck,
    output logic             lft,
    output logic             rght,
    output logic             frame_strt,
    output logic             motors_armed
);

    localparam int unsigned ARM_CNT_W = (ARM_FRAMES > 32'd1) ? $clog2(ARM_FRAMES) : 32'd1;
    localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(ARM_FRAMES - 32'd1);

    // Configuration sanity: the widest pulse must fit the width type and the frame
    localparam longint unsigned MAX_OFF_FB = (FRNT_OFF > BCK_OFF) ? 64'(FRNT_OFF) : 64'(BCK_OFF);
    localparam longint unsigned MAX_OFF_LR = (LFT_OFF > RGHT_OFF) ? 64'(LFT_OFF) : 64'(RGHT_OFF);
    localparam longint unsigned MAX_OFF    = (MAX_OFF_FB > MAX_OFF_LR) ? MAX_OFF_FB : MAX_OFF_LR;
    localparam longint unsigned MAX_W      = max_width(64'(BASE_PULSE), 64'(SPD_MULT), MAX_OFF);
    localparam longint unsigned FRAME_LEN  = 64'd1 << PERIOD_BITS;

    generate
        if ((MAX_W >= FRAME_LEN) || (MAX_W >= (64'd1 << WIDTH_W))) begin : g_bad_width
            $error("esc_quad: maximum pulse width does not fit in the frame or width type");
        end
        if (ARM_FRAMES < 32'd1) begin : g_bad_arm
            $error("esc_quad: ARM_FRAMES must be at least 1");
        end
    endgenerate

    logic [PERIOD_BITS-1:0] cnt_r;
    logic [PERIOD_BITS-1:0] cnt_nxt_s;
    logic                   boundary_s;
    esc_state_e             state_r;
    esc_state_e             state_nxt_s;
    logic [ARM_CNT_W-1:0]   arm_cnt_r;
    logic [ARM_CNT_W-1:0]   arm_cnt_nxt_s;
    logic                   armed_nxt_s;
    logic                   frame_strt_nxt_s;
    logic                   armed_r;
    logic                   frame_strt_r;

    // Frame counter wraps naturally; the boundary is the cycle before it returns to zero
    always_comb begin
        cnt_nxt_s  = cnt_r + PERIOD_BITS'(1'b1);
        boundary_s = (cnt_r == {PERIOD_BITS{1'b1}});
    end

    // Free-running frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {PERIOD_BITS{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Arming state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            arm_cnt_r <= {ARM_CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            arm_cnt_r <= arm_cnt_nxt_s;
        end
    end

    // Next arming state; arm is looked at only on the frame boundary
    always_comb begin
        state_nxt_s   = state_r;
        arm_cnt_nxt_s = arm_cnt_r;
        if (boundary_s) begin
            if (!arm) begin
                state_nxt_s   = IDLE;
                arm_cnt_nxt_s = {ARM_CNT_W{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        state_nxt_s   = ARMING;
                        arm_cnt_nxt_s = {ARM_CNT_W{1'b0}};
                    end
                    ARMING: begin
                        if (arm_cnt_r == ARM_LAST) begin
                            state_nxt_s   = ARMED;
                            arm_cnt_nxt_s = {ARM_CNT_W{1'b0}};
                        end else begin
                            state_nxt_s   = ARMING;
                            arm_cnt_nxt_s = arm_cnt_r + ARM_CNT_W'(1'b1);
                        end
                    end
                    ARMED: begin
                        state_nxt_s   = ARMED;
                        arm_cnt_nxt_s = arm_cnt_r;
                    end
                    default: begin
                        state_nxt_s   = IDLE;
                        arm_cnt_nxt_s = {ARM_CNT_W{1'b0}};
                    end
                endcase
            end
        end else begin
            state_nxt_s   = state_r;
            arm_cnt_nxt_s = arm_cnt_r;
        end
    end

    // Status outputs derived from the state being entered
    always_comb begin
        armed_nxt_s      = (state_nxt_s == ARMED);
        frame_strt_nxt_s = boundary_s;
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r      <= 1'b0;
            frame_strt_r <= 1'b0;
        end else begin
            armed_r      <= armed_nxt_s;
            frame_strt_r <= frame_strt_nxt_s;
        end
    end

    assign motors_armed = armed_r;
    assign frame_strt   = frame_strt_r;

    esc_chan #(
        .PERIOD_BITS (PERIOD_BITS),
        .BASE_PULSE  (BASE_PULSE),
        .SPD_MULT    (SPD_MULT),
        .OFF         (FRNT_OFF)
    ) u_frnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (boundary_s),
        .mode    (state_nxt_s),
        .spd     (frnt_spd),
        .cnt_nxt (cnt_nxt_s),
        .pwm     (frnt)
    );

    esc_chan #(
        .PERIOD_BITS (PERIOD_BITS),
        .BASE_PULSE  (BASE_PULSE),
        .SPD_MULT    (SPD_MULT),
        .OFF         (BCK_OFF)
    ) u_bck (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (boundary_s),
        .mode    (state_nxt_s),
        .spd     (bck_spd),
        .cnt_nxt (cnt_nxt_s),
        .pwm     (bck)
    );

    esc_chan #(
        .PERIOD_BITS (PERIOD_BITS),
        .BASE_PULSE  (BASE_PULSE),
        .SPD_MULT    (SPD_MULT),
        .OFF         (LFT_OFF)
    ) u_lft (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (boundary_s),
        .mode    (state_nxt_s),
        .spd     (lft_spd),
        .cnt_nxt (cnt_nxt_s),
        .pwm     (lft)
    );

    esc_chan #(
        .PERIOD_BITS (PERIOD_BITS),
        .BASE_PULSE  (BASE_PULSE),
        .SPD_MULT    (SPD_MULT),
        .OFF         (RGHT_OFF)
    ) u_rght (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (boundary_s),
        .mode    (state_nxt_s),
        .spd     (rght_spd),
        .cnt_nxt (cnt_nxt_s),
        .pwm     (rght)
    );

endmodule

// File: tb/tb_esc_quad.sv
// Testbench for esc_quad, scaled down for simulation speed: 4096-cycle frames,
// 100-cycle base pulse, 1 cycle per speed LSB, distinct per-motor trims and
// 4 arming frames. Each frame's measured pulse widths, armed time and length
// are compared with expectations queued when that frame's inputs were driven.
module tb_esc_quad;

    localparam int FRAME = 4096;
    // Arming-frame widths: base 100 plus trim (front 1023, back 0, left 5, right 17)
    localparam int AF = 1123;
    localparam int AB = 100;
    localparam int AL = 105;
    localparam int AR = 117;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        arm = 1'b0;
    logic [10:0] frnt_spd = 11'd0;
    logic [10:0] bck_spd = 11'd0;
    logic [10:0] lft_spd = 11'd0;
    logic [10:0] rght_spd = 11'd0;
    logic        frnt, bck, lft, rght, frame_strt, motors_armed;
    logic [3:0]  pwm;

    assign pwm = {rght, lft, bck, frnt};

    esc_quad #(
        .PERIOD_BITS (12),
        .BASE_PULSE  (100),
        .SPD_MULT    (1),
        .FRNT_OFF    (10'd1023),
        .BCK_OFF     (10'd0),
        .LFT_OFF     (10'd5),
        .RGHT_OFF    (10'd17),
        .ARM_FRAMES  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .frnt_spd     (frnt_spd),
        .bck_spd      (bck_spd),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .frnt         (frnt),
        .bck          (bck),
        .lft          (lft),
        .rght         (rght),
        .frame_strt   (frame_strt),
        .motors_armed (motors_armed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][16:0] w;
        logic             armed;
    } exp_t;

    typedef struct packed {
        logic             arm;
        logic             glitch;
        logic [3:0][10:0] spd;
        exp_t             exp;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    logic mon_en = 1'b0;
    logic first_frame = 1'b1;
    int   cyc_cnt = 0;
    int   hi_cnt[4];
    int   armed_cnt = 0;
    int   frame_no = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic add_vec(input logic a, input logic g,
                           input logic [10:0] sf, input logic [10:0] sb,
                           input logic [10:0] sl, input logic [10:0] sr,
                           input int wf, input int wb, input int wl, input int wr,
                           input logic ar);
        vec_t v;
        v.arm       = a;
        v.glitch    = g;
        v.spd       = {sr, sl, sb, sf};
        v.exp.w     = {17'(wr), 17'(wl), 17'(wb), 17'(wf)};
        v.exp.armed = ar;
        vecs.push_back(v);
    endtask

    task automatic mon_start();
        cyc_cnt   = 0;
        armed_cnt = 0;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        first_frame = 1'b1;
        mon_en      = 1'b1;
    endtask

    task automatic end_frame();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame%0d: frame ended with no expectation queued", frame_no);
        end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++)
                check($sformatf("frame%0d width ch%0d", frame_no, c), hi_cnt[c], e.w[c]);
            check($sformatf("frame%0d armed cycles", frame_no), armed_cnt, e.armed ? cyc_cnt : 0);
            if (!first_frame)
                check($sformatf("frame%0d length", frame_no), cyc_cnt, FRAME);
        end
        frame_no++;
        cyc_cnt   = 0;
        armed_cnt = 0;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        first_frame = 1'b0;
    endtask

    // Per-frame monitor: high cycles per pin, armed cycles and frame length
    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_strt) end_frame();
            cyc_cnt++;
            for (int c = 0; c < 4; c++) if (pwm[c]) hi_cnt[c]++;
            if (motors_armed) armed_cnt++;
        end
    end

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_strt && n < FRAME + 16);
        if (!frame_strt) begin
            checks++;
            failures++;
            $display("FAIL frame_strt timeout: none within %0d cycles", n);
        end
    endtask

    initial begin
        int   n;
        exp_t zero_e;
        zero_e = '{w: 68'd0, armed: 1'b0};

        // arm glitch speeds F B L R                expected widths F B L R   armed
        add_vec(1'b0, 1'b0, 11'h400, 11'h400, 11'h400, 11'h400, 0, 0, 0, 0, 1'b0);
        add_vec(1'b1, 1'b0, 11'h400, 11'h400, 11'h400, 11'h400, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b0, 11'h400, 11'h400, 11'h400, 11'h400, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b1, 11'h400, 11'h400, 11'h400, 11'h400, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b0, 11'h400, 11'h400, 11'h400, 11'h400, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b0, 11'h100, 11'h400, 11'h000, 11'h7FF, 1379, 1124, 105, 2164, 1'b1);
        add_vec(1'b1, 1'b0, 11'h7FF, 11'h001, 11'h3FF, 11'h555, 3170, 101, 1128, 1482, 1'b1);
        add_vec(1'b0, 1'b0, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 0, 0, 0, 0, 1'b0);
        add_vec(1'b0, 1'b1, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 0, 0, 0, 0, 1'b0);
        add_vec(1'b1, 1'b0, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b0, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b0, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b0, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, AF, AB, AL, AR, 1'b0);
        add_vec(1'b1, 1'b0, 11'h123, 11'h123, 11'h123, 11'h123, 1414, 391, 396, 408, 1'b1);

        // Reset with arm requested and full-scale speeds: outputs must stay low
        arm = 1'b1;
        frnt_spd = 11'h7FF; bck_spd = 11'h7FF; lft_spd = 11'h7FF; rght_spd = 11'h7FF;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset pwm", pwm, 0);
        check("reset frame_strt", frame_strt, 0);
        check("reset motors_armed", motors_armed, 0);
        arm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_start();
        exp_q.push_back(zero_e);
        repeat (50) @(negedge clk);

        // Inputs for each frame are driven ~50 cycles into the previous frame,
        // i.e. while that frame's pulses are still high
        foreach (vecs[i]) begin
            arm      = vecs[i].arm;
            frnt_spd = vecs[i].spd[0];
            bck_spd  = vecs[i].spd[1];
            lft_spd  = vecs[i].spd[2];
            rght_spd = vecs[i].spd[3];
            exp_q.push_back(vecs[i].exp);
            if (vecs[i].glitch) begin
                repeat (10) @(negedge clk);
                arm = ~vecs[i].arm;
                repeat (20) @(negedge clk);
                arm = vecs[i].arm;
            end
            wait_fs(n);
            repeat (50) @(negedge clk);
        end
        wait_fs(n);
        @(negedge clk);
        check("queue drained after table", exp_q.size(), 0);

        // Asynchronous reset while all pulses are high
        repeat (50) @(negedge clk);
        check("pwm high before reset", pwm, 15);
        check("armed before reset", motors_armed, 1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset pwm", pwm, 0);
        check("async reset motors_armed", motors_armed, 0);
        check("async reset frame_strt", frame_strt, 0);
        arm = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_start();
        exp_q.push_back(zero_e);
        exp_q.push_back(zero_e);
        wait_fs(n);
        check("cycles to first frame_strt after reset", n, FRAME);
        wait_fs(n);
        @(negedge clk);
        check("queue drained after reset", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
